// File: rtl/chi3_dual_pass_sequencer_if.sv
// Purpose : request/response bundle for chi3_dual_pass_sequencer.
// Ports   : in_valid/in_ready/in_data carry the request. out_valid/out_ready/out_data/out_err
//           carry the result. Rows are packed 6 bits each as {c1,c0,b1,b0,a1,a0}.
interface chi3_dual_pass_sequencer_if #(
  parameter int NROWS = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [6*NROWS-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [6*NROWS-1:0]   out_data;
  logic                 out_err;

  // The slave side is the sequencer. The master side is the producer/consumer around it.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/chi3_dual_pass_sequencer.sv
// Purpose : runs each 2-share Chi3 row twice through one masked core and compares the passes
//           share-wise. The whole block is zeroed if any row disagrees.
// Latency : 2*NROWS+1 cycles from the accept edge to out_valid. Backpressure holds OUT until out_ready.
// Ports   : clk and rst (async, active-high). bus uses the slave modport. fi_mask_i is a fault-injection
//           hook that is only applied in P2. fault_sticky_o stays set until rst.
module chi3_dual_pass_sequencer #(
  parameter int NROWS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  chi3_dual_pass_sequencer_if.slave       bus,
  input  logic [5:0]                      fi_mask_i,
  output logic                            fault_sticky_o
);

  localparam int W  = 6 * NROWS;
  localparam int RW = (NROWS > 1) ? $clog2(NROWS) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(NROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_P1, S_P2, S_OUT} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_idx_q, row_idx_d;
  logic            mismatch_q, mismatch_d;
  logic            sticky_q, sticky_d;
  logic [W-1:0]    in_q;
  logic [W-1:0]    result_q;
  logic [5:0]      pass1_q;

  logic            accept;
  logic [5:0]      row_in;
  logic [5:0]      core_o;
  logic [5:0]      p2_val;
  logic            share0_ok;
  logic            share1_ok;
  logic            row_mismatch;

  // This is a masked Chi3 on one row {c1,c0,b1,b0,a1,a0}.
  // The nonlinear term (~x & y) is expanded over the shares. The inversion sits on share 0 only.
  // Each output share gathers cross products, but no wire ever holds x0^x1.
  function automatic logic [5:0] chi3_core(input logic [5:0] r);
    logic a0, a1, b0, b1, c0, c1;
    logic [5:0] o;
    a0 = r[0]; a1 = r[1];
    b0 = r[2]; b1 = r[3];
    c0 = r[4]; c1 = r[5];
    o[0] = a0 ^ (~b0 & c0) ^ (~b0 & c1);
    o[1] = a1 ^ ( b1 & c0) ^ ( b1 & c1);
    o[2] = b0 ^ (~c0 & a0) ^ (~c0 & a1);
    o[3] = b1 ^ ( c1 & a0) ^ ( c1 & a1);
    o[4] = c0 ^ (~a0 & b0) ^ (~a0 & b1);
    o[5] = c1 ^ ( a1 & b0) ^ ( a1 & b1);
    return o;
  endfunction

  assign accept = (state_q == S_IDLE) && bus.in_valid;
  assign row_in = in_q[6*row_idx_q +: 6];
  assign core_o = chi3_core(row_in);

  // The injected fault only reaches the second pass, so it always shows up as a disagreement.
  assign p2_val = core_o ^ ((state_q == S_P2) ? fi_mask_i : 6'd0);

  // Each share is compared only against the same share of the other pass.
  assign share0_ok    = (p2_val[0] == pass1_q[0]) && (p2_val[2] == pass1_q[2]) && (p2_val[4] == pass1_q[4]);
  assign share1_ok    = (p2_val[1] == pass1_q[1]) && (p2_val[3] == pass1_q[3]) && (p2_val[5] == pass1_q[5]);
  assign row_mismatch = !(share0_ok && share1_ok);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    row_idx_d  = row_idx_q;
    mismatch_d = mismatch_q;
    sticky_d   = sticky_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d    = S_P1;
          row_idx_d  = '0;
          mismatch_d = 1'b0;
        end
      end
      S_P1: begin
        state_d = S_P2;
      end
      S_P2: begin
        if (row_mismatch) begin
          mismatch_d = 1'b1;
          sticky_d   = 1'b1;
        end
        if (row_idx_q == LAST_ROW) begin
          state_d = S_OUT;
        end else begin
          row_idx_d = row_idx_q + RW'(1);
          state_d   = S_P1;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic. out_data stays zero outside OUT and for a faulted request, so nothing leaks partially.
  always_comb begin
    bus.in_ready   = (state_q == S_IDLE);
    bus.out_valid  = (state_q == S_OUT);
    bus.out_err    = (state_q == S_OUT) && mismatch_q;
    bus.out_data   = ((state_q == S_OUT) && !mismatch_q) ? result_q : '0;
    fault_sticky_o = sticky_q;
  end

  // Datapath and control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_idx_q  <= '0;
      mismatch_q <= 1'b0;
      sticky_q   <= 1'b0;
      in_q       <= '0;
      pass1_q    <= '0;
      result_q   <= '0;
    end else begin
      row_idx_q  <= row_idx_d;
      mismatch_q <= mismatch_d;
      sticky_q   <= sticky_d;
      if (accept) begin
        in_q <= bus.in_data;
      end
      if (state_q == S_P1) begin
        pass1_q <= core_o;
      end
      if (state_q == S_P2) begin
        result_q[6*row_idx_q +: 6] <= pass1_q;
      end
    end
  end

endmodule

// File: tb/tb_chi3_dual_pass_sequencer.sv
// Purpose : scoreboard bench for chi3_dual_pass_sequencer with NROWS=4.
// Stimulus: directed vectors (clean, fault-injected, reset abort, backpressure, busy, masked sweep).
// Checking: expectations are queued at issue, and a negedge monitor pops and compares them on each output handshake.
module tb_chi3_dual_pass_sequencer;

  localparam int NROWS = 4;
  localparam int W     = 6 * NROWS;
  localparam int LAT   = 2 * NROWS + 1;

  // Rows (a,b,c) = (1,0,1),(0,0,1),(1,1,1),(0,1,0), with share1 = 0
  localparam logic [W-1:0]  IN_DIR  = {6'h04, 6'h15, 6'h10, 6'h11};
  // Chi3 rows (0,0,1),(1,0,1),(1,1,1),(0,1,1), with share1 = 0
  localparam logic [W-1:0]  EXP_DIR = {6'h14, 6'h15, 6'h11, 6'h10};
  // The same result unmasked, as {c,b,a} per row
  localparam logic [11:0]   EXP_UNM = {3'b110, 3'b111, 3'b101, 3'b100};

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] fi_mask;
  logic       fault_sticky;

  chi3_dual_pass_sequencer_if #(.NROWS(NROWS)) bus ();

  chi3_dual_pass_sequencer #(.NROWS(NROWS)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .fi_mask_i      (fi_mask),
    .fault_sticky_o (fault_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dat;
    logic         err;
    bit           unm;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 60000) begin
      $display("FAIL watchdog: cycle %0d, required below 60000", cyc);
      $fatal(1, "bench timeout");
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [2:0] chi_unm(input logic [2:0] x);
    logic a, b, c;
    a = x[0]; b = x[1]; c = x[2];
    return {c ^ (~a & b), b ^ (~c & a), a ^ (~b & c)};
  endfunction

  function automatic logic [5:0] mask_row(input logic [2:0] x, input logic [2:0] m);
    return {m[2], x[2] ^ m[2], m[1], x[1] ^ m[1], m[0], x[0] ^ m[0]};
  endfunction

  function automatic logic [11:0] unmask(input logic [W-1:0] d);
    logic [11:0] u;
    u = '0;
    for (int r = 0; r < NROWS; r++) begin
      u[3*r +: 3] = {d[6*r+4] ^ d[6*r+5], d[6*r+2] ^ d[6*r+3], d[6*r] ^ d[6*r+1]};
    end
    return u;
  endfunction

  function automatic logic [11:0] model(input logic [W-1:0] d);
    logic [11:0] u;
    logic [11:0] o;
    u = unmask(d);
    o = '0;
    for (int r = 0; r < NROWS; r++) begin
      o[3*r +: 3] = chi_unm(u[3*r +: 3]);
    end
    return o;
  endfunction

  // ---------------- monitor ----------------
  logic         pv_valid = 1'b0;
  logic         pv_hs    = 1'b0;
  logic [W-1:0] pv_data  = '0;
  int           acc_cyc  = -1;
  exp_t         mon_e;

  always @(negedge clk) begin
    if (rst) begin
      pv_valid = 1'b0;
      pv_hs    = 1'b0;
      pv_data  = '0;
    end else begin
      if (bus.in_valid && bus.in_ready) acc_cyc = cyc;
      if (pv_hs) begin
        check("in_ready_after_release", W'(bus.in_ready), W'(1));
        check("out_valid_after_release", W'(bus.out_valid), W'(0));
      end
      if (bus.out_valid) begin
        check("in_ready_low_in_out", W'(bus.in_ready), W'(0));
        if (!pv_valid) check("latency", W'(cyc - acc_cyc), W'(LAT));
        else           check("out_data_hold", bus.out_data, pv_data);
        if (bus.out_ready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got data %h, required no output", bus.out_data);
          end else begin
            mon_e = sb.pop_front();
            if (mon_e.unm) check("out_data_unmasked", W'(unmask(bus.out_data)), mon_e.dat);
            else           check("out_data", bus.out_data, mon_e.dat);
            check("out_err", W'(bus.out_err), W'(mon_e.err));
          end
        end
      end
      pv_valid = bus.out_valid;
      pv_hs    = bus.out_valid && bus.out_ready;
      pv_data  = bus.out_data;
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [W-1:0] d, input bit push, input exp_t e);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.in_ready && n < 200);
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready got 0, required 1");
    end else begin
      if (push) sb.push_back(e);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data  = ~d;   // later changes must not be captured
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_pending", W'(sb.size()), W'(0));
  endtask

  exp_t          e;
  logic [W-1:0]  d;
  int            acc_idx[$];
  int            n;

  initial begin
    rst          = 1'b1;
    fi_mask      = 6'd0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_out_valid", W'(bus.out_valid), W'(0));
    check("reset_in_ready", W'(bus.in_ready), W'(1));
    check("reset_out_data", bus.out_data, '0);
    check("reset_out_err", W'(bus.out_err), W'(0));
    check("reset_sticky", W'(fault_sticky), W'(0));

    // Single clean directed request
    e = '{dat: EXP_DIR, err: 1'b0, unm: 1'b0};
    send(IN_DIR, 1'b1, e);
    wait_drain();
    check("sticky_after_clean", W'(fault_sticky), W'(0));

    // Fault injected only in the row-2 P2 cycle
    e = '{dat: '0, err: 1'b1, unm: 1'b0};
    send(IN_DIR, 1'b1, e);
    repeat (5) @(posedge clk);
    #1 fi_mask = 6'b000001;
    @(posedge clk);
    #1 fi_mask = 6'd0;
    wait_drain();
    check("sticky_after_fault", W'(fault_sticky), W'(1));

    // The next clean request passes while sticky stays set
    e = '{dat: EXP_DIR, err: 1'b0, unm: 1'b0};
    send(IN_DIR, 1'b1, e);
    wait_drain();
    check("sticky_kept", W'(fault_sticky), W'(1));

    // Reset in the middle of row-1 P2 aborts the request without output
    send(IN_DIR, 1'b0, e);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", W'(bus.out_valid), W'(0));
    check("abort_in_ready", W'(bus.in_ready), W'(1));
    check("abort_sticky", W'(fault_sticky), W'(0));
    check("abort_out_data", bus.out_data, '0);

    // Backpressure: hold OUT for 5 cycles (the monitor checks hold and in_ready)
    bus.out_ready = 1'b0;
    e = '{dat: EXP_DIR, err: 1'b0, unm: 1'b0};
    send(IN_DIR, 1'b1, e);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_out_valid", W'(bus.out_valid), W'(1));
    repeat (5) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_drain();

    // Busy ignore: in_valid held high and in_data changing every cycle
    for (int k = 0; k < 22; k++) begin
      d = W'({$urandom, $urandom});
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      if (bus.in_ready) begin
        acc_idx.push_back(k);
        e = '{dat: W'(model(d)), err: 1'b0, unm: 1'b1};
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    wait_drain();
    check("busy_accept_count", W'(acc_idx.size()), W'(3));
    if (acc_idx.size() >= 2) begin
      check("busy_first_accept", W'(acc_idx[0]), W'(0));
      check("busy_second_accept", W'(acc_idx[1]), W'(2*NROWS+2));
    end

    // Random share1 with the same unmasked rows
    for (int i = 0; i < 1000; i++) begin
      d = {mask_row(3'b010, 3'($urandom)), mask_row(3'b111, 3'($urandom)),
           mask_row(3'b100, 3'($urandom)), mask_row(3'b101, 3'($urandom))};
      e = '{dat: W'(EXP_UNM), err: 1'b0, unm: 1'b1};
      send(d, 1'b1, e);
    end
    wait_drain();
    check("sticky_after_random", W'(fault_sticky), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chi3_dual_pass_sequencer.md
# chi3_dual_pass_sequencer

Sequencer that time-shares one combinational 2-share Toffoli-based Chi3 core across NROWS 3-bit rows of a masked state. Each row is evaluated twice on the same core, and the two results are compared share-wise, giving temporal redundancy against fault and SIFA attacks. The full result block is released on a valid/ready interface, or zeroed when any mismatch is detected. The block sits between the masked state register and the next round stage.

## Interface
- NROWS, 4: rows per request, ≥1. The row counter is max(1,clog2(NROWS)) bits.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request. Asserted only in IDLE.
- in_data  in  6*NROWS  row r occupies bits [6r+5:6r] = {c1,c0,b1,b0,a1,a0}.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  6*NROWS  same layout as in_data, Chi3-mapped, shares preserved.
- out_err  out  1  valid with out_valid; 1 means at least one row mismatched.
- fault_sticky  out  1  set on any mismatch; cleared only by rst.
- fi_mask  in  6  test hook XORed into core output during P2 only; tie to 0 in product.

## Operation
- Core function per row, unmasked: a'=a^(~b&c), b'=b^(~c&a), c'=c^(~a&b). Shares stay split; the core never recombines them.
- Input register captures in_data on the accept edge (in_valid & in_ready). The core reads row[row_idx] from this register.
- FSM states:
  - IDLE: in_ready=1. On accept, row_idx←0 and go to P1.
  - P1: core result for row_idx → pass1 reg. Go to P2.
  - P2: core result ^ fi_mask compared share-wise with pass1 reg.
    - Share i matches when a_i, b_i and c_i are all equal; a row matches when both shares match.
    - Write the pass1 value into result[row_idx].
    - On mismatch, set the per-request mismatch flag and fault_sticky.
    - If row_idx==NROWS-1, go to OUT. Otherwise row_idx+1 and go to P1.
  - OUT: out_valid=1. out_data = mismatch flag ? 0 : result. out_err = mismatch flag. Go to IDLE on out_ready.
- The comparison works only on corresponding shares; no signal ever carries a share0^share1 combination.
- The mismatch flag clears on each accept. fault_sticky never clears except on rst.
- in_data changes outside the accept edge have no effect.
- A mismatch in any row zeroes the whole out_data block; no partial release.

## Timing
- Reset values: state=IDLE, in_ready=1 after reset deassertion, out_valid=0, out_data=0, out_err=0, fault_sticky=0, row_idx=0. Input, pass1 and result registers are all 0.
- Accept edge is T. P1 of row r is cycle T+1+2r; P2 of row r is cycle T+2+2r.
- out_valid first high in cycle T+2*NROWS+1, so latency is 2*NROWS+1 cycles.
- out_valid, out_data and out_err hold stable until the out_ready edge. in_ready returns 1 in the cycle after that edge.
- No accept in the same cycle as output release: throughput is at most one request per 2*NROWS+2 cycles.
- rst mid-operation: immediate abort, all outputs return to reset values, no partial output. fault_sticky clears as well.
- in_valid held high while busy: ignored; the request is accepted only in IDLE.
- fi_mask in IDLE, P1 or OUT: no effect.

## Test plan
- Reset: assert rst mid-P2 of row 1 with NROWS=4 → next cycle out_valid=0, in_ready=1, fault_sticky=0, out_data=0.
- Single request, NROWS=4, fi_mask=0: rows (a,b,c) = (1,0,1), (0,0,1), (1,1,1), (0,1,0) with share1=0 for all bits.
  - Required response: out_valid at T+9 and out_err=0.
  - Unmasked rows = (0,0,1), (1,0,1), (1,1,1), (0,1,1); share1 bits all still 0.
- Random masking: same unmasked rows with random share1 → share0^share1 of each output row equals the values above. 1000 random requests give out_err=0.
- Fault in P2: fi_mask=6'b000001 during row 2 P2 only → out_err=1, out_data=0, fault_sticky=1. The next clean request gives out_err=0 while fault_sticky stays 1.
- Backpressure: hold out_ready=0 for 5 cycles in OUT → out_data stable and in_ready=0 throughout. in_ready rises in the cycle after out_ready=1.
- Busy ignore: in_valid held high for whole request with in_data changing each cycle → only the first value is processed. The second accept occurs at T+2*NROWS+2 with out_ready=1.
